residual_partition_sequencer: RTL and testbench

Sequences residual decoding for one FLAC subframe. It walks the Rice partitions and fetches each 4-bit Rice parameter from the shared bit reader. It then enables the Rice decoder for exactly the number of residuals in that partition and forwards each residual with its sample index. It sits between the subframe header parser, which starts it, and the Rice decoder / bit reader pair, which it drives.

---
 rtl/residual_partition_sequencer_if.sv | 44 ++++
 rtl/residual_partition_sequencer.sv | 172 +++++++++++++++++
 tb/tb_residual_partition_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/residual_partition_sequencer_if.sv
// Bundles the start, bit-reader and Rice-decoder handshakes of the residual partition sequencer.
// The sequencer uses the slave view and its environment uses the master view.
interface residual_partition_sequencer_if;
  // Subframe header parser side
  logic               iStart;
  logic [15:0]        iBlockSize;
  logic [3:0]         iPredictorOrder;
  logic [3:0]         iPartitionOrder;

  // Bit reader side
  logic               oBitReq;
  logic [4:0]         oBitCount;
  logic               iBitValid;
  logic [15:0]        iBits;

  // Rice decoder side
  logic [3:0]         oRiceParam;
  logic               oRiceEnable;
  logic               iRiceValid;
  logic signed [15:0] iRiceResidual;

  // Residual stream and status
  logic signed [15:0] oResidual;
  logic               oValid;
  logic [15:0]        oSampleIdx;
  logic [15:0]        oPartition;
  logic               oBusy;
  logic               oDone;
  logic               oError;

  modport slave (
    input  iStart, iBlockSize, iPredictorOrder, iPartitionOrder,
    input  iBitValid, iBits, iRiceValid, iRiceResidual,
    output oBitReq, oBitCount, oRiceParam, oRiceEnable,
    output oResidual, oValid, oSampleIdx, oPartition, oBusy, oDone, oError
  );

  modport master (
    output iStart, iBlockSize, iPredictorOrder, iPartitionOrder,
    output iBitValid, iBits, iRiceValid, iRiceResidual,
    input  oBitReq, oBitCount, oRiceParam, oRiceEnable,
    input  oResidual, oValid, oSampleIdx, oPartition, oBusy, oDone, oError
  );
endinterface

// File: rtl/residual_partition_sequencer.sv
// Walks the Rice partitions of one FLAC subframe: fetches each 4-bit Rice parameter,
// enables the Rice decoder for that partition's residual count and forwards indexed residuals.
module residual_partition_sequencer (
  input  logic                                iClock,
  input  logic                                iReset,
  residual_partition_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PARAM_REQ,
    S_DECODE,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [3:0] RICE_ESCAPE = 4'hF;

  state_e             state_q, state_d;
  logic [15:0]        bs_q, bs_d;
  logic [3:0]         po_q, po_d;
  logic [3:0]         pred_q, pred_d;
  logic [15:0]        base_q, base_d;
  logic [15:0]        remaining_q, remaining_d;
  logic [15:0]        partition_q, partition_d;
  logic [15:0]        sample_idx_q, sample_idx_d;
  logic [3:0]         rice_param_q, rice_param_d;
  logic signed [15:0] residual_q, residual_d;
  logic               valid_q, valid_d;

  logic               start_ok;
  logic               bit_xfer;
  logic               rice_accept;
  logic               check_fail;
  logic               escape_param;
  logic [15:0]        base_calc;
  logic [15:0]        part_mask;
  logic [15:0]        pred_ext;
  logic               unused_bits;

  // The upper bit-reader bits carry nothing for a 4-bit request.
  assign unused_bits = ^bus.iBits[15:4];

  // Block geometry: partition mask doubles as the index of the last partition.
  always_comb begin
    base_calc    = bs_q >> po_q;
    part_mask    = (16'd1 << po_q) - 16'd1;
    pred_ext     = {12'd0, pred_q};
    check_fail   = (bs_q == 16'd0) || ((bs_q & part_mask) != 16'd0) || (base_calc < pred_ext);
    start_ok     = bus.iStart && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    bit_xfer     = (state_q == S_PARAM_REQ) && bus.iBitValid;
    rice_accept  = (state_q == S_DECODE) && bus.iRiceValid;
    escape_param = (bus.iBits[3:0] == RICE_ESCAPE);
  end

  // NOTE: sequential state is assigned only with non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q      <= S_IDLE;
      bs_q         <= 16'd0;
      po_q         <= 4'd0;
      pred_q       <= 4'd0;
      base_q       <= 16'd0;
      remaining_q  <= 16'd0;
      partition_q  <= 16'd0;
      sample_idx_q <= 16'd0;
      rice_param_q <= 4'd0;
      residual_q   <= 16'sd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bs_q         <= bs_d;
      po_q         <= po_d;
      pred_q       <= pred_d;
      base_q       <= base_d;
      remaining_q  <= remaining_d;
      partition_q  <= partition_d;
      sample_idx_q <= sample_idx_d;
      rice_param_q <= rice_param_d;
      residual_q   <= residual_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start_ok) state_d = S_CHECK;
      S_CHECK:                 state_d = check_fail ? S_ERROR : S_PARAM_REQ;
      S_PARAM_REQ: begin
        if (bit_xfer) begin
          if (escape_param)              state_d = S_ERROR;
          else if (remaining_q != 16'd0) state_d = S_DECODE;
          else                           state_d = S_NEXT;
        end
      end
      S_DECODE: if (rice_accept && remaining_q == 16'd1) state_d = S_NEXT;
      S_NEXT:   state_d = (partition_q == part_mask) ? S_DONE : S_PARAM_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates keyed on the current state.
  always_comb begin
    bs_d         = bs_q;
    po_d         = po_q;
    pred_d       = pred_q;
    base_d       = base_q;
    remaining_d  = remaining_q;
    partition_d  = partition_q;
    rice_param_d = rice_param_q;
    residual_d   = residual_q;
    valid_d      = 1'b0;
    // The index shown with a residual advances once that residual has been presented.
    sample_idx_d = valid_q ? sample_idx_q + 16'd1 : sample_idx_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_ok) begin
          bs_d         = bus.iBlockSize;
          po_d         = bus.iPartitionOrder;
          pred_d       = bus.iPredictorOrder;
          partition_d  = 16'd0;
          sample_idx_d = {12'd0, bus.iPredictorOrder};
        end
      end
      S_CHECK: begin
        base_d = base_calc;
        if (!check_fail) remaining_d = base_calc - pred_ext;
      end
      S_PARAM_REQ: begin
        if (bit_xfer && !escape_param) rice_param_d = bus.iBits[3:0];
      end
      S_DECODE: begin
        if (rice_accept) begin
          residual_d  = bus.iRiceResidual;
          valid_d     = 1'b1;
          remaining_d = remaining_q - 16'd1;
        end
      end
      S_NEXT: begin
        if (partition_q != part_mask) begin
          partition_d = partition_q + 16'd1;
          remaining_d = base_q;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from state or taken straight from flops, so reset clears them at once.
  always_comb begin
    bus.oBitReq     = (state_q == S_PARAM_REQ);
    bus.oBitCount   = (state_q == S_PARAM_REQ) ? 5'd4 : 5'd0;
    bus.oRiceEnable = (state_q == S_DECODE);
    bus.oRiceParam  = rice_param_q;
    bus.oResidual   = residual_q;
    bus.oValid      = valid_q;
    bus.oSampleIdx  = sample_idx_q;
    bus.oPartition  = partition_q;
    bus.oBusy       = (state_q == S_CHECK) || (state_q == S_PARAM_REQ) ||
                      (state_q == S_DECODE) || (state_q == S_NEXT);
    bus.oDone       = (state_q == S_DONE);
    bus.oError      = (state_q == S_ERROR);
  end

endmodule

// File: tb/tb_residual_partition_sequencer.sv
// Directed bench for residual_partition_sequencer: a bit-reader and Rice-decoder stand-in
// answer the DUT handshakes while each step compares outputs against hand-derived values.
module tb_residual_partition_sequencer;

  logic iClock = 1'b0;
  logic iReset = 1'b1;
  always #5 iClock = ~iClock;

  residual_partition_sequencer_if bus ();

  residual_partition_sequencer dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] prm [0:15];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":oBitReq"},     bus.oBitReq,     0);
    check({tag, ":oBitCount"},   bus.oBitCount,   0);
    check({tag, ":oRiceParam"},  bus.oRiceParam,  0);
    check({tag, ":oRiceEnable"}, bus.oRiceEnable, 0);
    check({tag, ":oResidual"},   bus.oResidual,   0);
    check({tag, ":oValid"},      bus.oValid,      0);
    check({tag, ":oSampleIdx"},  bus.oSampleIdx,  0);
    check({tag, ":oPartition"},  bus.oPartition,  0);
    check({tag, ":oBusy"},       bus.oBusy,       0);
    check({tag, ":oDone"},       bus.oDone,       0);
    check({tag, ":oError"},      bus.oError,      0);
  endtask

  // Starts one subframe and plays bit reader / Rice decoder until DONE, ERROR, reset or budget.
  task automatic run(input string name, input logic [15:0] bs, input logic [3:0] po,
                     input logic [3:0] pred, input int bit_delay, input bit rice_toggle,
                     input bit poke_start, input int reset_at,
                     output int n_valid, output int n_xfer, output int n_en,
                     output bit got_err, output bit got_done, output int cyc);
    logic [15:0]        base;
    logic signed [15:0] val;
    logic signed [15:0] exp_q [$];
    logic [15:0]        exp_idx;
    logic [15:0]        part;
    int  wait_cnt;
    int  pi;
    int  last_valid_cyc;
    bit  req_pending;
    bit  tgl;
    bit  poked;

    base = bs >> po;
    val  = 16'sh0123;
    n_valid = 0; n_xfer = 0; n_en = 0; got_err = 0; got_done = 0; cyc = 0;
    wait_cnt = 0; pi = 0; last_valid_cyc = 0; req_pending = 0; tgl = 0; poked = 0;

    bus.iBlockSize      = bs;
    bus.iPartitionOrder = po;
    bus.iPredictorOrder = pred;
    bus.iStart          = 1'b1;
    tick();
    bus.iStart = 1'b0;
    check({name, ":check_busy"},   bus.oBusy,   1);
    check({name, ":check_no_req"}, bus.oBitReq, 0);

    while (cyc < 2000) begin
      if (req_pending) check({name, ":bitreq_stable"}, bus.oBitReq, 1);
      if (bus.oError) begin got_err = 1; break; end
      if (bus.oDone) begin
        got_done = 1;
        if (n_valid > 0) check({name, ":done_latency"}, cyc - last_valid_cyc, 1);
        break;
      end

      // Inputs for the coming edge.
      bus.iStart     = 1'b0;
      bus.iBitValid  = 1'b0;
      bus.iBits      = 16'h0000;
      bus.iRiceValid = 1'b0;
      req_pending    = 1'b0;
      if (bus.oBitReq) begin
        check({name, ":bitcount"}, bus.oBitCount, 4);
        if (wait_cnt >= bit_delay) begin
          bus.iBitValid = 1'b1;
          bus.iBits     = {12'hA5C, prm[pi]};
          pi++;
          n_xfer++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
          req_pending = 1'b1;
        end
      end else if (bit_delay > 0) begin
        bus.iBitValid = 1'b1;
        bus.iBits     = 16'h000F;
      end

      tgl = rice_toggle ? ~tgl : 1'b1;
      if (tgl) begin
        bus.iRiceValid    = 1'b1;
        bus.iRiceResidual = val;
        if (bus.oRiceEnable) begin
          exp_q.push_back(val);
          n_en++;
        end
        val = val - 16'sd301;
      end

      if (poke_start && !poked && n_valid == 3) begin
        bus.iStart     = 1'b1;
        bus.iBlockSize = 16'd15;
        poked          = 1'b1;
      end

      tick();
      cyc++;
      bus.iBlockSize = bs;

      if (bus.oValid) begin
        n_valid++;
        last_valid_cyc = cyc;
        exp_idx = {12'd0, pred} + 16'(n_valid - 1);
        check({name, ":valid_has_accept"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check({name, ":residual"}, bus.oResidual, exp_q.pop_front());
        check({name, ":sample_idx"}, bus.oSampleIdx, exp_idx);
        if (base != 16'd0) begin
          part = exp_idx / base;
          check({name, ":partition"},  bus.oPartition, part);
          check({name, ":rice_param"}, bus.oRiceParam, prm[part[3:0]]);
        end
      end

      if (reset_at > 0 && n_valid == reset_at) begin
        #2 iReset = 1'b0;
        #1;
        break;
      end
    end
    check({name, ":terminated_in_budget"}, cyc < 2000, 1);
    bus.iStart     = 1'b0;
    bus.iBitValid  = 1'b0;
    bus.iRiceValid = 1'b0;
  endtask

  int n_valid, n_xfer, n_en, cyc;
  bit got_err, got_done;

  initial begin
    bus.iStart = 0; bus.iBlockSize = 0; bus.iPredictorOrder = 0; bus.iPartitionOrder = 0;
    bus.iBitValid = 0; bus.iBits = 0; bus.iRiceValid = 0; bus.iRiceResidual = 0;
    for (int i = 0; i < 16; i++) prm[i] = 4'd0;

    #2 iReset = 1'b0;
    #1 check_all_zero("reset");
    tick();
    tick();
    iReset = 1'b1;
    tick();
    check_all_zero("post_reset_idle");

    // Four partitions of 2,4,4,4 residuals.
    prm[0] = 4'd3; prm[1] = 4'd4; prm[2] = 4'd5; prm[3] = 4'd6;
    run("bs16", 16'd16, 4'd2, 4'd2, 0, 1'b0, 1'b0, 0, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("bs16:valid_count", n_valid, 14);
    check("bs16:xfers",       n_xfer,  4);
    check("bs16:done",        got_done, 1);
    check("bs16:oDone",       bus.oDone, 1);
    check("bs16:oBusy",       bus.oBusy, 0);
    tick();
    check("bs16:done_held",   bus.oDone, 1);

    // Block size not divisible by the partition count.
    run("bs15", 16'd15, 4'd2, 4'd2, 0, 1'b0, 1'b0, 0, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("bs15:error",       got_err, 1);
    check("bs15:err_latency", cyc, 1);
    check("bs15:xfers",       n_xfer, 0);
    check("bs15:oBusy",       bus.oBusy, 0);
    check("bs15:oBitReq",     bus.oBitReq, 0);
    check("bs15:oDone",       bus.oDone, 0);

    // Single partition, no warm-up, restarted from ERROR.
    prm[0] = 4'd7;
    run("bs16po0", 16'd16, 4'd0, 4'd0, 0, 1'b0, 1'b0, 0, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("bs16po0:valid_count", n_valid, 16);
    check("bs16po0:xfers",       n_xfer,  1);
    check("bs16po0:done",        got_done, 1);
    check("bs16po0:oError",      bus.oError, 0);

    // Empty first partition: warm-up consumes all of partition 0.
    prm[0] = 4'd2; prm[1] = 4'd9;
    run("empty0", 16'd8, 4'd1, 4'd4, 0, 1'b0, 1'b0, 0, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("empty0:valid_count", n_valid, 4);
    check("empty0:xfers",       n_xfer,  2);
    check("empty0:enables",     n_en,    4);
    check("empty0:done",        got_done, 1);

    // Escape code on the second parameter.
    prm[0] = 4'd3; prm[1] = 4'hF;
    run("escape", 16'd16, 4'd2, 4'd2, 0, 1'b0, 1'b0, 0, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("escape:error",       got_err, 1);
    check("escape:valid_count", n_valid, 2);
    check("escape:xfers",       n_xfer,  2);
    check("escape:rice_off",    bus.oRiceEnable, 0);
    check("escape:valid_off",   bus.oValid, 0);
    bus.iRiceValid = 1'b1;
    tick();
    check("escape:rice_off2",   bus.oRiceEnable, 0);
    check("escape:valid_off2",  bus.oValid, 0);
    check("escape:error_held",  bus.oError, 1);
    bus.iRiceValid = 1'b0;

    // Slow bit reader, bursty Rice decoder and an ignored restart.
    prm[0] = 4'd3; prm[1] = 4'd4; prm[2] = 4'd5; prm[3] = 4'd6;
    run("slow", 16'd16, 4'd2, 4'd2, 3, 1'b1, 1'b1, 0, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("slow:valid_count", n_valid, 14);
    check("slow:xfers",       n_xfer,  4);
    check("slow:done",        got_done, 1);
    check("slow:no_error",    got_err, 0);

    // Reset mid-decode, then a clean run.
    run("abort", 16'd16, 4'd2, 4'd2, 0, 1'b0, 1'b0, 5, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("abort:valid_count", n_valid, 5);
    check_all_zero("abort_async");
    tick();
    check_all_zero("abort_held");
    iReset = 1'b1;
    tick();
    check_all_zero("abort_idle");
    run("after", 16'd16, 4'd2, 4'd2, 0, 1'b0, 1'b0, 0, n_valid, n_xfer, n_en, got_err, got_done, cyc);
    check("after:valid_count", n_valid, 14);
    check("after:done",        got_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
